// File: rtl/pet_display_pkg.sv
// rtl/pet_display_pkg.sv - screen/expression encodings, menu modes and colour defaults
package pet_display_pkg;

   typedef enum logic [2:0] {
      SCR_EXPR    = 3'd0,
      SCR_MENU    = 3'd1,
      SCR_SETTING = 3'd2,
      SCR_GAME    = 3'd3,
      SCR_POTATO  = 3'd4
   } scr_t;

   typedef enum logic [2:0] {
      EXP_IDLE    = 3'd0,
      EXP_HAPPY   = 3'd1,
      EXP_SATISFY = 3'd2,
      EXP_SLEEP   = 3'd3,
      EXP_EXPECT  = 3'd4
   } expr_t;

   localparam logic [15:0] COL_SET_DEF  = 16'h1111;
   localparam logic [15:0] COL_GAME_DEF = 16'h5555;
   localparam logic [15:0] COL_POT_DEF  = 16'h0000;

   localparam logic [2:0] MODE_GAME    = 3'd0;
   localparam logic [2:0] MODE_POTATO  = 3'd1;
   localparam logic [2:0] MODE_SETTING = 3'd2;

   // Reserved cursor positions map back to MENU so a press there is a no-op.
   function automatic scr_t mode_to_scr(input logic [2:0] mode);
      case (mode)
         MODE_GAME:    return SCR_GAME;
         MODE_POTATO:  return SCR_POTATO;
         MODE_SETTING: return SCR_SETTING;
         default:      return SCR_MENU;
      endcase
   endfunction

   function automatic logic enc_legal(input logic [2:0] enc);
      return (enc <= 3'd4);
   endfunction

endpackage

// File: rtl/pet_display_ctrl_tick_timer.sv
// rtl/pet_display_ctrl_tick_timer.sv - saturating tick counter that flags when a limit is reached
module tick_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_clear,
   input  logic       i_en,
   input  logic [7:0] i_limit,
   output logic       o_done
);

   logic [7:0] r_cnt;

   assign o_done = (r_cnt == i_limit);

   // Holds at the limit so done stays asserted until the owner clears it.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= 8'd0;
      end else if (i_en && i_tick && !o_done) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/pet_display_ctrl.sv
// rtl/pet_display_ctrl.sv - pet screen/expression FSMs with frame-synchronous commit and pixel mux
module pet_display_ctrl
   import pet_display_pkg::*;
#(
   parameter int               PIX_W    = 16,
   parameter int               N_MODES  = 3,
   parameter int               TICK_CYC = 100_000_000,
   parameter int               IDLE_TO  = 10,
   parameter int               MENU_TO  = 10,
   parameter logic [PIX_W-1:0] COL_SET  = PIX_W'(COL_SET_DEF),
   parameter logic [PIX_W-1:0] COL_GAME = PIX_W'(COL_GAME_DEF),
   parameter logic [PIX_W-1:0] COL_POT  = PIX_W'(COL_POT_DEF)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       go,
   input  logic                       awaking,
   input  logic                       touched,
   input  logic                       expecting,
   input  logic                       petting,
   input  logic                       pressed,
   input  logic                       left,
   input  logic                       right,
   input  logic                       frame_start,
   input  logic [PIX_W-1:0]           pix_idle,
   input  logic [PIX_W-1:0]           pix_happy,
   input  logic [PIX_W-1:0]           pix_satisfy,
   input  logic [PIX_W-1:0]           pix_sleep,
   input  logic [PIX_W-1:0]           pix_expect,
   input  logic [PIX_W-1:0]           pix_menu,
   output logic [PIX_W-1:0]           pix_out,
   output logic [2:0]                 state_o,
   output logic [2:0]                 expr_o,
   output logic [$clog2(N_MODES)-1:0] mode_o
);

   localparam int             MW        = $clog2(N_MODES);
   localparam logic [MW-1:0]  MODE_LAST = MW'(N_MODES - 1);
   localparam int             TW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYC - 1);

   logic [2:0]       r_btn_d;
   logic [2:0]       r_btn_q;
   logic [2:0]       w_btn_e;
   logic             w_press_e;
   logic             w_left_e;
   logic             w_right_e;

   logic [TW-1:0]    r_tick_cnt;
   logic             w_tick;

   logic             w_idle_en;
   logic             w_idle_done;
   logic             w_menu_en;
   logic             w_menu_clear;
   logic             w_menu_done;

   scr_t             r_scr;
   expr_t            r_expr;
   scr_t             w_scr_nx;
   expr_t            w_expr_nx;
   logic [2:0]       r_state;
   logic [2:0]       r_expr_c;
   logic [MW-1:0]    r_mode;
   logic [PIX_W-1:0] r_pix;

   // Bit order {right, left, pressed}; edges come from the registered copy only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_d <= 3'b000;
         r_btn_q <= 3'b000;
      end else begin
         r_btn_d <= {right, left, pressed};
         r_btn_q <= r_btn_d;
      end
   end

   assign w_btn_e   = r_btn_d & ~r_btn_q;
   assign w_press_e = w_btn_e[0];
   assign w_left_e  = w_btn_e[1];
   assign w_right_e = w_btn_e[2];

   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   assign w_idle_en    = (r_scr == SCR_EXPR) && (r_expr == EXP_IDLE);
   assign w_menu_en    = (r_scr == SCR_MENU);
   assign w_menu_clear = !w_menu_en || w_press_e || w_left_e || w_right_e;

   tick_timer u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (w_tick),
      .i_clear (!w_idle_en),
      .i_en    (w_idle_en),
      .i_limit (8'(IDLE_TO)),
      .o_done  (w_idle_done)
   );

   tick_timer u_menu_timer (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (w_tick),
      .i_clear (w_menu_clear),
      .i_en    (w_menu_en),
      .i_limit (8'(MENU_TO)),
      .o_done  (w_menu_done)
   );

   // A press beats a coincident timeout; cursor moves restart the timer instead.
   always_comb begin
      w_scr_nx = r_scr;
      case (r_scr)
         SCR_EXPR: begin
            if (w_press_e) w_scr_nx = SCR_MENU;
         end
         SCR_MENU: begin
            if (w_press_e) begin
               w_scr_nx = mode_to_scr(3'(r_mode));
            end else if (w_menu_done && !w_left_e && !w_right_e) begin
               w_scr_nx = SCR_EXPR;
            end
         end
         SCR_SETTING, SCR_GAME, SCR_POTATO: begin
            if (w_press_e) w_scr_nx = SCR_MENU;
         end
         default: w_scr_nx = SCR_EXPR;
      endcase
   end

   always_comb begin
      w_expr_nx = r_expr;
      if (r_scr == SCR_EXPR) begin
         case (r_expr)
            EXP_IDLE: begin
               if (w_idle_done)         w_expr_nx = EXP_SLEEP;
               else if (expecting)      w_expr_nx = EXP_EXPECT;
               else if (touched || go)  w_expr_nx = EXP_HAPPY;
            end
            EXP_HAPPY: begin
               if (go || !touched) w_expr_nx = EXP_IDLE;
            end
            EXP_SATISFY: begin
               if (!petting) w_expr_nx = EXP_EXPECT;
            end
            EXP_SLEEP: begin
               if (awaking) w_expr_nx = EXP_IDLE;
            end
            EXP_EXPECT: begin
               if (!expecting || w_press_e) w_expr_nx = EXP_IDLE;
               else if (petting)            w_expr_nx = EXP_SATISFY;
            end
            default: w_expr_nx = EXP_IDLE;
         endcase
      end else if (!enc_legal(r_expr)) begin
         w_expr_nx = EXP_IDLE;
      end
   end

   // Pending state tracks the FSMs every cycle; the visible copy only moves on frame_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scr    <= SCR_EXPR;
         r_expr   <= EXP_IDLE;
         r_state  <= SCR_EXPR;
         r_expr_c <= EXP_IDLE;
      end else begin
         r_scr  <= w_scr_nx;
         r_expr <= w_expr_nx;
         if (frame_start) begin
            r_state  <= w_scr_nx;
            r_expr_c <= w_expr_nx;
         end
         if (!enc_legal(r_state)) begin
            r_state <= SCR_EXPR;
            r_scr   <= SCR_EXPR;
         end
         if (!enc_legal(r_expr_c)) begin
            r_expr_c <= EXP_IDLE;
            r_expr   <= EXP_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= '0;
      end else if ((r_scr == SCR_MENU) && (w_left_e ^ w_right_e)) begin
         if (w_right_e) begin
            r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
         end else begin
            r_mode <= (r_mode == '0) ? MODE_LAST : r_mode - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix <= '0;
      end else begin
         case (r_state)
            SCR_EXPR: begin
               case (r_expr_c)
                  EXP_IDLE:    r_pix <= pix_idle;
                  EXP_HAPPY:   r_pix <= pix_happy;
                  EXP_SATISFY: r_pix <= pix_satisfy;
                  EXP_SLEEP:   r_pix <= pix_sleep;
                  EXP_EXPECT:  r_pix <= pix_expect;
                  default:     r_pix <= '0;
               endcase
            end
            SCR_MENU:    r_pix <= pix_menu;
            SCR_SETTING: r_pix <= COL_SET;
            SCR_GAME:    r_pix <= COL_GAME;
            SCR_POTATO:  r_pix <= COL_POT;
            default:     r_pix <= '0;
         endcase
      end
   end

   assign pix_out = r_pix;
   assign state_o = r_state;
   assign expr_o  = r_expr_c;
   assign mode_o  = r_mode;

endmodule

// File: tb/tb_pet_display_ctrl.sv
// tb/tb_pet_display_ctrl.sv - scoreboard bench for pet_display_ctrl with directed scenarios
module tb_pet_display_ctrl;

   logic        clk;
   logic        rst;
   logic        go, awaking, touched, expecting, petting;
   logic        pressed, left, right;
   logic        frame_start;
   logic [15:0] pix_idle, pix_happy, pix_satisfy, pix_sleep, pix_expect, pix_menu;
   logic [15:0] pix_out;
   logic [2:0]  state_o;
   logic [2:0]  expr_o;
   logic [1:0]  mode_o;

   typedef struct {
      string       name;
      logic [2:0]  st;
      logic [2:0]  ex;
      logic [1:0]  md;
      logic [15:0] px;
   } exp_t;

   exp_t exp_q[$];
   int   total;
   int   bad;

   pet_display_ctrl #(
      .PIX_W    (16),
      .N_MODES  (3),
      .TICK_CYC (4),
      .IDLE_TO  (3),
      .MENU_TO  (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .awaking     (awaking),
      .touched     (touched),
      .expecting   (expecting),
      .petting     (petting),
      .pressed     (pressed),
      .left        (left),
      .right       (right),
      .frame_start (frame_start),
      .pix_idle    (pix_idle),
      .pix_happy   (pix_happy),
      .pix_satisfy (pix_satisfy),
      .pix_sleep   (pix_sleep),
      .pix_expect  (pix_expect),
      .pix_menu    (pix_menu),
      .pix_out     (pix_out),
      .state_o     (state_o),
      .expr_o      (expr_o),
      .mode_o      (mode_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame();
      frame_start = 1'b1;
      cyc(1);
      frame_start = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [2:0] st, input logic [2:0] ex,
                             input logic [1:0] md, input logic [15:0] px);
      exp_t e;
      e.name = name;
      e.st   = st;
      e.ex   = ex;
      e.md   = md;
      e.px   = px;
      exp_q.push_back(e);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (state_o !== e.st || expr_o !== e.ex || mode_o !== e.md || pix_out !== e.px) begin
               bad++;
               $display("FAIL %s: got state=%0d expr=%0d mode=%0d pix=%h, want state=%0d expr=%0d mode=%0d pix=%h",
                        e.name, state_o, expr_o, mode_o, pix_out, e.st, e.ex, e.md, e.px);
            end
         end
      end
   end

   initial begin
      logic [1:0] left_seq [3];
      left_seq[0] = 2'd2;
      left_seq[1] = 2'd1;
      left_seq[2] = 2'd0;

      rst = 1'b1;
      {go, awaking, touched, expecting, petting} = 5'b0;
      {pressed, left, right} = 3'b0;
      frame_start = 1'b0;
      pix_idle    = 16'hA001;
      pix_happy   = 16'hA002;
      pix_satisfy = 16'hA003;
      pix_sleep   = 16'hA004;
      pix_expect  = 16'hA005;
      pix_menu    = 16'hB00B;

      cyc(3);
      expect_out("reset", 3'd0, 3'd0, 2'd0, 16'h0000);
      rst = 1'b0;

      cyc(1);
      expect_out("idle_pix", 3'd0, 3'd0, 2'd0, 16'hA001);
      cyc(47);
      expect_out("sleep_hidden", 3'd0, 3'd0, 2'd0, 16'hA001);
      frame();
      expect_out("sleep_commit", 3'd0, 3'd3, 2'd0, 16'hA001);
      cyc(1);
      expect_out("sleep_pix", 3'd0, 3'd3, 2'd0, 16'hA004);

      awaking = 1'b1;
      cyc(1);
      awaking = 1'b0;
      frame();
      expect_out("wake", 3'd0, 3'd0, 2'd0, 16'hA004);

      touched = 1'b1;
      cyc(5);
      touched = 1'b0;
      expect_out("touch_hidden", 3'd0, 3'd0, 2'd0, 16'hA001);
      cyc(1);
      frame();
      expect_out("touch_glitch", 3'd0, 3'd0, 2'd0, 16'hA001);

      expecting = 1'b1;
      cyc(1);
      petting = 1'b1;
      cyc(1);
      frame();
      expect_out("satisfy", 3'd0, 3'd2, 2'd0, 16'hA001);
      cyc(1);
      expect_out("satisfy_pix", 3'd0, 3'd2, 2'd0, 16'hA003);
      petting = 1'b0;
      cyc(1);
      frame();
      expect_out("expect", 3'd0, 3'd4, 2'd0, 16'hA003);
      expecting = 1'b0;
      cyc(1);
      expect_out("expect_pix", 3'd0, 3'd4, 2'd0, 16'hA005);

      pressed = 1'b1;
      cyc(10);
      pressed = 1'b0;
      expect_out("menu_hidden", 3'd0, 3'd4, 2'd0, 16'hA005);
      frame();
      expect_out("menu_commit", 3'd1, 3'd0, 2'd0, 16'hA005);
      cyc(1);
      expect_out("menu_pix", 3'd1, 3'd0, 2'd0, 16'hB00B);

      for (int i = 0; i < 3; i++) begin
         left = 1'b1;
         cyc(1);
         left = 1'b0;
         cyc(2);
         expect_out($sformatf("left_%0d", i), 3'd1, 3'd0, left_seq[i], 16'hB00B);
      end
      right = 1'b1;
      cyc(1);
      right = 1'b0;
      cyc(2);
      expect_out("right_wrap", 3'd1, 3'd0, 2'd1, 16'hB00B);
      left  = 1'b1;
      right = 1'b1;
      cyc(1);
      left  = 1'b0;
      right = 1'b0;
      cyc(2);
      expect_out("simul_lr", 3'd1, 3'd0, 2'd1, 16'hB00B);
      left = 1'b1;
      cyc(1);
      left = 1'b0;
      cyc(2);
      expect_out("left_back", 3'd1, 3'd0, 2'd0, 16'hB00B);

      pressed = 1'b1;
      cyc(1);
      pressed = 1'b0;
      frame();
      expect_out("game_commit", 3'd3, 3'd0, 2'd0, 16'hB00B);
      cyc(1);
      expect_out("game_pix", 3'd3, 3'd0, 2'd0, 16'h5555);

      rst = 1'b1;
      cyc(1);
      expect_out("midframe_rst", 3'd0, 3'd0, 2'd0, 16'h0000);
      rst = 1'b0;

      pressed = 1'b1;
      cyc(1);
      pressed = 1'b0;
      cyc(1);
      right = 1'b1;
      cyc(1);
      right = 1'b0;
      cyc(2);
      expect_out("mode1", 3'd0, 3'd0, 2'd1, 16'hA001);
      cyc(22);
      pressed = 1'b1;
      cyc(1);
      pressed = 1'b0;
      cyc(1);
      expect_out("press_vs_to_hidden", 3'd0, 3'd0, 2'd1, 16'hA001);
      frame();
      expect_out("potato", 3'd4, 3'd0, 2'd1, 16'hA001);
      cyc(1);
      expect_out("potato_pix", 3'd4, 3'd0, 2'd1, 16'h0000);

      pressed = 1'b1;
      cyc(1);
      pressed = 1'b0;
      cyc(1);
      cyc(14);
      frame();
      expect_out("menu_pre_to", 3'd1, 3'd0, 2'd1, 16'h0000);
      cyc(15);
      frame();
      expect_out("menu_timeout", 3'd0, 3'd0, 2'd1, 16'hB00B);
      cyc(1);
      expect_out("idle_pix2", 3'd0, 3'd0, 2'd1, 16'hA001);

      cyc(2);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d checks left unserviced, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
